// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and access sequencer for the memory shared by
// instruction fetch (requester 0) and data access (requester 1).
//
// state  | meaning
// IDLE   | no access in progress; sel holds the last owner
// ACCESS | owner holds the memory; count runs down to the ack cycle
module mem_port_arbiter #(
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic       sel,
  output logic       mem_en,
  output logic       busy
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] RELOAD = CW'(LATENCY - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic          owner;
  logic          ptr;
  logic [CW-1:0] count;
  logic [1:0]    masked;
  logic          last;
  logic          winner;

  // On a tie the requester that was not granted most recently wins.
  function automatic logic arbitrate(input logic [1:0] r, input logic p);
    if (r == 2'b11) return ~p;
    else            return r[1];
  endfunction

  assign winner = arbitrate(req, ptr);
  assign last   = (state == ACCESS) && (count == '0);
  // The finishing owner's still-high request is not eligible for the handover decision.
  assign masked = req & ~(owner ? 2'b10 : 2'b01);
  assign ack    = last ? gnt : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      count  <= '0;
      gnt    <= 2'b00;
      sel    <= 1'b0;
      mem_en <= 1'b0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            state  <= ACCESS;
            owner  <= winner;
            ptr    <= winner;
            count  <= RELOAD;
            gnt    <= winner ? 2'b10 : 2'b01;
            sel    <= winner;
            mem_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ACCESS: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else if (masked != 2'b00) begin
            owner <= ~owner;
            ptr   <= ~owner;
            count <= RELOAD;
            gnt   <= owner ? 2'b01 : 2'b10;
            sel   <= ~owner;
          end else begin
            state  <= IDLE;
            gnt    <= 2'b00;
            mem_en <= 1'b0;
            busy   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three instances (LATENCY 1, 2, 3), a vector
// table plus hand sequences, and random traffic against a transaction model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a  [3];
  logic [1:0] req_a  [3];
  logic [1:0] gnt_a  [3];
  logic [1:0] ack_a  [3];
  logic       sel_a  [3];
  logic       men_a  [3];
  logic       busy_a [3];

  mem_port_arbiter #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(rst_a[0]), .req(req_a[0]), .gnt(gnt_a[0]),
    .ack(ack_a[0]), .sel(sel_a[0]), .mem_en(men_a[0]), .busy(busy_a[0]));
  mem_port_arbiter #(.LATENCY(2)) u_l2 (
    .clk(clk), .reset_n(rst_a[1]), .req(req_a[1]), .gnt(gnt_a[1]),
    .ack(ack_a[1]), .sel(sel_a[1]), .mem_en(men_a[1]), .busy(busy_a[1]));
  mem_port_arbiter #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(rst_a[2]), .req(req_a[2]), .gnt(gnt_a[2]),
    .ack(ack_a[2]), .sel(sel_a[2]), .mem_en(men_a[2]), .busy(busy_a[2]));

  typedef struct {
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic       sel;
    logic       busy;
  } vec_t;

  vec_t tbl [23];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int k, input logic [1:0] eg,
                       input logic [1:0] ea, input logic es, input logic eb);
    logic [6:0] act, exp;
    act = {gnt_a[k], ack_a[k], sel_a[k], men_a[k], busy_a[k]};
    exp = {eg, ea, es, eb, eb};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lat%0d t=%0t: got gnt=%b ack=%b sel=%b mem_en=%b busy=%b, expected gnt=%b ack=%b sel=%b mem_en=%b busy=%b",
               name, k + 1, $time, gnt_a[k], ack_a[k], sel_a[k], men_a[k], busy_a[k],
               eg, ea, es, eb, eb);
    end
  endtask

  task automatic cycle(input int k, input logic [1:0] r);
    req_a[k] = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k);
    rst_a[k] = 1'b0;
    req_a[k] = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", k, 2'b00, 2'b00, 1'b0, 1'b0);
    rst_a[k] = 1'b1;
    req_a[k] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_release", k, 2'b00, 2'b00, 1'b0, 1'b0);
    end
  endtask

  // Model: rem = access cycles still to run including the current one.
  task automatic rand_run(input int k, input int n);
    int         lat, rem;
    logic       mo, mp;
    logic [1:0] r, masked, eg;
    lat = k + 1;
    rem = 0;
    mo  = 1'b0;
    mp  = 1'b0;
    r   = 2'b00;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 0) r = 2'($urandom_range(0, 3));
      req_a[k] = r;
      @(posedge clk);
      if (rem == 0) begin
        if (r != 2'b00) begin
          mo  = (r == 2'b11) ? ~mp : r[1];
          mp  = mo;
          rem = lat;
        end
      end else if (rem == 1) begin
        masked = r & ~(2'b01 << mo);
        if (masked != 2'b00) begin
          mo  = ~mo;
          mp  = mo;
          rem = lat;
        end else begin
          rem = 0;
        end
      end else begin
        rem = rem - 1;
      end
      #1;
      eg = (rem > 0) ? (2'b01 << mo) : 2'b00;
      check("random", k, eg, (rem == 1) ? eg : 2'b00, mo, rem > 0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst_a[k] = 1'b0;
      req_a[k] = 2'b00;
    end

    // LATENCY=2, starting from reset: single fetch, tie, fairness, no preemption.
    tbl[0]  = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[1]  = '{2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[2]  = '{2'b01, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[4]  = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[5]  = '{2'b11, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[6]  = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[7]  = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[8]  = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[9]  = '{2'b11, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[10] = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[11] = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[12] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[13] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    tbl[14] = '{2'b01, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[15] = '{2'b11, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[16] = '{2'b10, 2'b10, 2'b00, 1'b1, 1'b1};
    tbl[17] = '{2'b10, 2'b10, 2'b10, 1'b1, 1'b1};
    tbl[18] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[19] = '{2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
    tbl[20] = '{2'b11, 2'b01, 2'b00, 1'b0, 1'b1};
    tbl[21] = '{2'b00, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[22] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0};

    do_reset(1);
    for (int i = 0; i < 23; i++) begin
      cycle(1, tbl[i].req);
      check($sformatf("tbl%0d", i), 1, tbl[i].gnt, tbl[i].ack, tbl[i].sel, tbl[i].busy);
    end

    // LATENCY=1: one-cycle accesses alternate under continuous requests.
    do_reset(0);
    cycle(0, 2'b11); check("l1_first", 0, 2'b10, 2'b10, 1'b1, 1'b1);
    cycle(0, 2'b11); check("l1_alt0",  0, 2'b01, 2'b01, 1'b0, 1'b1);
    cycle(0, 2'b11); check("l1_alt1",  0, 2'b10, 2'b10, 1'b1, 1'b1);
    cycle(0, 2'b00); check("l1_idle",  0, 2'b00, 2'b00, 1'b1, 1'b0);

    // LATENCY=3: reset in the second access cycle, then a clean access.
    do_reset(2);
    cycle(2, 2'b01); check("l3_acc1", 2, 2'b01, 2'b00, 1'b0, 1'b1);
    cycle(2, 2'b01); check("l3_acc2", 2, 2'b01, 2'b00, 1'b0, 1'b1);
    rst_a[2] = 1'b0;
    #1;
    check("l3_mid_reset", 2, 2'b00, 2'b00, 1'b0, 1'b0);
    #1;
    rst_a[2] = 1'b1;
    cycle(2, 2'b01); check("l3_re1",  2, 2'b01, 2'b00, 1'b0, 1'b1);
    cycle(2, 2'b01); check("l3_re2",  2, 2'b01, 2'b00, 1'b0, 1'b1);
    cycle(2, 2'b01); check("l3_re3",  2, 2'b01, 2'b01, 1'b0, 1'b1);
    cycle(2, 2'b00); check("l3_idle", 2, 2'b00, 2'b00, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      do_reset(k);
      rand_run(k, 1500);
      req_a[k] = 2'b00;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer for the single-ported memory shared by instruction fetch (requester 0) and data access (requester 1).
- Drives the select line of the 2:1 mux bank that steers address, write data and control into the memory.
- Holds each grant for a fixed multi-cycle access and returns a one-cycle acknowledge to the owner.
- The pipeline hazard logic stalls any stage whose request is pending and not yet acknowledged.

Parameters:
LATENCY, 2, memory access length in clock cycles; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge active
reset_n  input  1  asynchronous, active-low reset
req  input  2  request lines; bit0 = fetch, bit1 = data; level, held until acknowledged
gnt  output  2  one-hot grant; high for every cycle of the owner's access
ack  output  2  one-cycle pulse on the owner's bit during the last access cycle
sel  output  1  mux-bank select = current or most recent owner index
mem_en  output  1  memory enable, high during every access cycle
busy  output  1  high whenever an access is in progress

Behaviour:
- State: IDLE / ACCESS, plus:
  - owner register (1 bit);
  - last-granted pointer (1 bit);
  - down-counter of width clog2(LATENCY+1).
- Reset (reset_n low, asynchronous, takes effect immediately, also mid-access):
  - state=IDLE, owner=0, pointer=0, count=0;
  - gnt=00, ack=00, sel=0, mem_en=0, busy=0.
- Arbitration function over a 2-bit request vector r:
  - one bit set → that bit wins;
  - both set → the index not equal to the pointer wins;
  - the pointer resets to 0, so data (1) wins the first tie.
- IDLE:
  - req=00 → stay IDLE; sel holds the previous owner.
  - Otherwise, at the rising edge, latch owner = arbitrate(req), set pointer = owner, count = LATENCY-1, go to ACCESS.
- ACCESS:
  - gnt[owner]=1, mem_en=1, busy=1, sel=owner.
  - count>0 → decrement at each edge.
  - count==0 is the final access cycle: ack[owner]=1 combinationally from state and count.
- Leaving ACCESS (edge at end of the ack cycle):
  - The owner's req bit is masked to 0 for this decision; a still-high owner req counts as a new request from the next cycle on.
  - The masked vector is non-zero → back-to-back grant to the other requester, no idle cycle; pointer = new owner, count reloads.
  - Otherwise → IDLE.
- Fixed latency: req sampled high in IDLE at edge E → gnt/mem_en valid from E until edge E+LATENCY; ack high in the cycle before E+LATENCY.
- LATENCY=1: every access is one cycle, ack coincides with the first gnt cycle, and continuous requests alternate every cycle.
- No preemption: a request from the non-owner during ACCESS waits until the current access ends.
- Owner drops req mid-access: protocol violation; the access still completes and ack still pulses.
- Invariants:
  - gnt is always one-hot or zero;
  - ack is a subset of gnt;
  - gnt equals zero exactly when busy=0.
- All outputs change only on clk rising edges or on asynchronous reset; there are no combinational paths from req to any output.

Test Plan:
- Reset: reset_n=0 with req=11 → gnt=00, ack=00, sel=0, mem_en=0, busy=0; these hold for two cycles after reset_n releases with req=00.
- Single fetch, LATENCY=2:
  - req=01 sampled at edge 0 → gnt=01, mem_en=1, sel=0 in cycles 1–2;
  - ack=01 in cycle 2 only;
  - req dropped after ack → busy=0 in cycle 3.
- Tie after reset, LATENCY=2:
  - req=11 held → data first: sel=1,1 with ack=10 in cycle 2;
  - then fetch back-to-back: sel=0,0 with ack=01 in cycle 4;
  - no idle cycle between the two accesses.
- Fairness: both requests held high for 4 transactions (each re-raised after ack) → grant order 1,0,1,0 and 4 ack pulses in 8 cycles.
- No preemption: req=01 granted, req[1] raised in the first access cycle → fetch completes and acks, then data is granted on the next edge.
- Mid-access reset, LATENCY=3:
  - reset_n pulsed low in the 2nd access cycle → all outputs clear immediately, no ack issued;
  - after release with req=01 → full 3-cycle access with ack in the 3rd cycle.
